// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encodings
// and the upper bound of the 12 KiB DM word range (also used by the DM decoder).
package dm_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam logic [31:0] DM_UPPER = 32'h2FFF;

  function automatic logic dm_in_range(input logic [31:0] addr);
    return (addr <= DM_UPPER);
  endfunction

endpackage

// File: rtl/dm_arb_fsm.sv
// Grant decision and burst tracking for the DM port arbiter.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module dm_arb_fsm
  import dm_port_arbiter_pkg::*;
#(
  parameter int BURST_MAX    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic dma_last,
  output logic cpu_gnt,
  output logic dma_gnt
);

  arb_state_t state;
  logic [2:0] beat_cnt;
  logic [2:0] beat_next;
  logic       starve_fire;

  assign beat_next = beat_cnt + 3'd1;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign starve_fire = (starve_cnt == 4'(STARVE_LIMIT));

  // Counts consecutive denied DMA cycles; any DMA grant restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (dma_gnt) begin
      starve_cnt <= 4'd0;
    end else if (dma_req && !starve_fire) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starve_fire = 1'b0;
`endif

  // Nothing is granted while reset is held, so a dropped burst never writes.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state == ARB_BURST) begin
        dma_gnt = dma_req;
      end else if (dma_req && starve_fire) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else begin
        dma_gnt = dma_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      beat_cnt <= 3'd0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (dma_gnt) begin
            beat_cnt <= 3'd1;
            if (!dma_last && (BURST_MAX > 1)) state <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (dma_req) begin
            beat_cnt <= beat_next;
            if (dma_last || (beat_next == 3'(BURST_MAX))) state <= ARB_IDLE;
          end else begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single DM port between the CPU M-stage and a DMA/debug master.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int BURST_MAX    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        exc_int,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_err,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic        cpu_gnt;
  logic        dma_in_range;
  logic [11:0] mem_addr_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[31:14], cpu_addr[1:0]};

  dm_arb_fsm #(
    .BURST_MAX    (BURST_MAX),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .dma_last (dma_last),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt)
  );

  assign dma_in_range = dm_in_range(dma_addr);
  assign cpu_rdata    = mem_rdata;
  assign cpu_stall    = cpu_req & ~cpu_gnt;

  // Port mux; an idle port keeps presenting the last granted word index.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    mem_addr  = mem_addr_q;
    if (cpu_gnt) begin
      mem_we    = cpu_we & ~exc_int;
      mem_be    = cpu_be;
      mem_wdata = cpu_wdata;
      mem_addr  = cpu_addr[13:2];
    end else if (dma_gnt) begin
      mem_we    = dma_we & dma_in_range;
      mem_be    = dma_be;
      mem_wdata = dma_wdata;
      mem_addr  = dma_addr[13:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q <= 12'd0;
    end else if (cpu_gnt || dma_gnt) begin
      mem_addr_q <= mem_addr;
    end
  end

  // Out-of-range beats are consumed silently apart from the error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rdata  <= 32'd0;
      dma_rvalid <= 1'b0;
      dma_err    <= 1'b0;
    end else begin
      dma_rvalid <= dma_gnt & ~dma_we & dma_in_range;
      dma_err    <= dma_gnt & ~dma_in_range;
      if (dma_gnt && !dma_we && dma_in_range) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a small DM model.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, exc_int;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_last;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] dm [0:4095];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.BURST_MAX(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .exc_int    (exc_int),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_be     (dma_be),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_last   (dma_last),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_err    (dma_err),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // DM storage: combinational read, byte-lane write on the clock edge
  assign mem_rdata = dm[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dm[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cwe, input logic [31:0] caddr,
                               input logic [31:0] cwd, input logic exc,
                               input logic dr, input logic dwe, input logic [31:0] daddr,
                               input logic [31:0] dwd, input logic dl);
    cpu_req  = cr;  cpu_we  = cwe; cpu_addr  = caddr; cpu_wdata = cwd; exc_int = exc;
    dma_req  = dr;  dma_we  = dwe; dma_addr  = daddr; dma_wdata = dwd; dma_last = dl;
    cpu_be   = 4'hF; dma_be = 4'hF;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) dm[i] = 32'd0;
    reset = 1'b1;
    idle(); tick(); tick();
    reset = 1'b0;

    // reset state
    idle();
    checkOutput("rst_stall", 32'(cpu_stall), 0);
    checkOutput("rst_gnt", 32'(dma_gnt), 0);
    checkOutput("rst_we", 32'(mem_we), 0);
    checkOutput("rst_rvalid", 32'(dma_rvalid), 0);
    checkOutput("rst_err", 32'(dma_err), 0);
    checkOutput("rst_rdata", dma_rdata, 0);
    checkOutput("rst_addr", 32'(mem_addr), 0);
    tick();

    // CPU store then load
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    checkOutput("sw_we", 32'(mem_we), 1);
    checkOutput("sw_stall", 32'(cpu_stall), 0);
    checkOutput("sw_addr", 32'(mem_addr), 32'h4);
    tick();
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lw_data", cpu_rdata, 32'hDEADBEEF);
    checkOutput("lw_we", 32'(mem_we), 0);
    tick();

    // 3-beat DMA write burst, CPU arrives on beat 2
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h100, 32'h11111111, 0);
    checkOutput("b3_gnt1", 32'(dma_gnt), 1);
    checkOutput("b3_addr1", 32'(mem_addr), 32'h40);
    checkOutput("b3_we1", 32'(mem_we), 1);
    tick();
    applyStimulus(1, 0, 32'h10, 0, 0, 1, 1, 32'h104, 32'h22222222, 0);
    checkOutput("b3_gnt2", 32'(dma_gnt), 1);
    checkOutput("b3_stall2", 32'(cpu_stall), 1);
    tick();
    applyStimulus(1, 0, 32'h10, 0, 0, 1, 1, 32'h108, 32'h33333333, 1);
    checkOutput("b3_gnt3", 32'(dma_gnt), 1);
    checkOutput("b3_stall3", 32'(cpu_stall), 1);
    tick();
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b3_cpu_after", 32'(cpu_stall), 0);
    checkOutput("b3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    applyStimulus(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b3_mem_104", cpu_rdata, 32'h22222222);
    tick();

    // 6-beat burst broken after BURST_MAX beats
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h200, 32'hA1, 0);
    checkOutput("b6_gnt1", 32'(dma_gnt), 1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1, 0, 32'h10, 0, 0, 1, 1, 32'h200 + 32'(4*(k-1)), 32'hA0 + 32'(k), 0);
      checkOutput($sformatf("b6_gnt%0d", k), 32'(dma_gnt), 1);
      checkOutput($sformatf("b6_stall%0d", k), 32'(cpu_stall), 1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 32'h10, 0, 0, 1, 1, 32'h210, 32'hA5, 0);
      checkOutput("b6_break_gnt", 32'(dma_gnt), 0);
      checkOutput("b6_break_stall", 32'(cpu_stall), 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h210, 32'hA5, 0);
    checkOutput("b6_gnt5", 32'(dma_gnt), 1);
    checkOutput("b6_addr5", 32'(mem_addr), 32'h84);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h214, 32'hA6, 1);
    checkOutput("b6_gnt6", 32'(dma_gnt), 1);
    tick();

    // CPU store suppressed by exception
    applyStimulus(1, 1, 32'h10, 32'h12345678, 1, 0, 0, 0, 0, 0);
    checkOutput("exc_we", 32'(mem_we), 0);
    checkOutput("exc_stall", 32'(cpu_stall), 0);
    tick();
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_mem", cpu_rdata, 32'hDEADBEEF);
    tick();

    // DMA range boundary and out-of-range beats
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h2FFC, 32'h5A5A5A5A, 1);
    checkOutput("top_we", 32'(mem_we), 1);
    checkOutput("top_addr", 32'(mem_addr), 32'hBFF);
    tick();
    idle();
    checkOutput("hold_addr", 32'(mem_addr), 32'hBFF);
    checkOutput("top_err", 32'(dma_err), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h3000, 32'hFFFFFFFF, 1);
    checkOutput("oor_w_gnt", 32'(dma_gnt), 1);
    checkOutput("oor_w_we", 32'(mem_we), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h3000, 0, 1);
    checkOutput("oor_r_gnt", 32'(dma_gnt), 1);
    checkOutput("oor_w_err", 32'(dma_err), 1);
    tick();
    idle();
    checkOutput("oor_r_err", 32'(dma_err), 1);
    checkOutput("oor_r_rvalid", 32'(dma_rvalid), 0);
    checkOutput("oor_mem_0", dm[0], 32'd0);
    tick();
    idle();
    checkOutput("oor_err_clear", 32'(dma_err), 0);
    tick();

    // In-range single-beat DMA read
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h104, 0, 1);
    checkOutput("rd_gnt", 32'(dma_gnt), 1);
    tick();
    idle();
    checkOutput("rd_rvalid", 32'(dma_rvalid), 1);
    checkOutput("rd_rdata", dma_rdata, 32'h22222222);
    checkOutput("rd_err", 32'(dma_err), 0);
    tick();
    idle();
    checkOutput("rd_rvalid_pulse", 32'(dma_rvalid), 0);
    tick();

    // Simultaneous requests: starvation behaviour
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 0, 32'h10, 0, 0, 1, 0, 32'h104, 0, 1);
      checkOutput($sformatf("stv_gnt%0d", k), 32'(dma_gnt), 0);
      checkOutput($sformatf("stv_stall%0d", k), 32'(cpu_stall), 0);
      tick();
    end
    applyStimulus(1, 0, 32'h10, 0, 0, 1, 0, 32'h104, 0, 1);
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("stv_gnt9", 32'(dma_gnt), 1);
    checkOutput("stv_stall9", 32'(cpu_stall), 1);
`else
    checkOutput("stv_gnt9", 32'(dma_gnt), 0);
    checkOutput("stv_stall9", 32'(cpu_stall), 0);
`endif
    tick();
    idle();
    tick();

    // Reset in the middle of a 4-beat DMA read burst
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0);
    checkOutput("rb_gnt1", 32'(dma_gnt), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h104, 0, 0);
    checkOutput("rb_gnt2", 32'(dma_gnt), 1);
    checkOutput("rb_rdata1", dma_rdata, 32'h11111111);
    tick();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h108, 0, 0);
    checkOutput("rb_rst_gnt", 32'(dma_gnt), 0);
    checkOutput("rb_rst_we", 32'(mem_we), 0);
    tick();
    reset = 1'b0;
    applyStimulus(1, 0, 32'h100, 0, 0, 1, 0, 32'h108, 0, 0);
    checkOutput("rb_cpu_stall", 32'(cpu_stall), 0);
    checkOutput("rb_dma_gnt", 32'(dma_gnt), 0);
    checkOutput("rb_rvalid", 32'(dma_rvalid), 0);
    checkOutput("rb_cpu_rdata", cpu_rdata, 32'h11111111);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
